keypad_encoder_n: RTL and testbench
===================================

KEYPAD_ENCODER_N -- requirements
Module: keypad_encoder_n

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 10: number of raw key inputs, legal range 2..16.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples required for press or release, legal range >= 1.
REQ-003 SHALL have parameter DIV_RATIO, default 100: clock-enable divide ratio, legal range >= 2.
REQ-004 SHALL have parameter DIGITS, default 4: depth of the entered-digit register, in BCD digits, legal range >= 1.
REQ-005 SHALL use one clock and a reset that is synchronous and active-high.
REQ-006 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port Keypad, input, NUM_KEYS bits: raw key lines, active-high.
REQ-009 SHALL have port Enablen, input, 1 bit: low = entry mode, high = run mode.
REQ-010 SHALL have port Clear, input, 1 bit: synchronous clear of the digit register.
REQ-011 SHALL have port D, output, 4 bits: code of the last accepted key.
REQ-012 SHALL have port loadn, output, 1 bit: active-low one-cycle key-accept strobe.
REQ-013 SHALL have port pgt_1Hz, output, 1 bit: one-cycle tick.
REQ-014 SHALL have port Digits, output, 4*DIGITS bits: shift register of entered digits; the newest digit is in bits [3:0].
REQ-015 SHALL have port DigitCount, output, clog2(DIGITS+1) bits: number of stored digits.
REQ-016 SHALL have port Full, output, 1 bit: high when DigitCount == DIGITS.

Function
REQ-017 SHALL priority-encode Keypad each cycle, highest set index wins; no key set = "none".
REQ-018 SHALL run a debounce FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a stable-sample counter.
REQ-019 SHALL apply these IDLE and PRESS_WAIT transitions:
- IDLE, code sampled -> PRESS_WAIT, count=1.
- PRESS_WAIT, same code sampled -> count+1.
- PRESS_WAIT, different code sampled -> restart count at 1 with the new code.
- PRESS_WAIT, none sampled -> IDLE.
REQ-020 SHALL, on the edge where count reaches DEBOUNCE_CYCLES:
- enter HELD;
- register D = code;
- drive loadn low for exactly the following cycle.
REQ-021 SHALL apply these HELD and RELEASE_WAIT transitions:
- HELD, none sampled -> RELEASE_WAIT, count=1.
- HELD, code changed -> stay HELD with no new accept.
- RELEASE_WAIT, none for DEBOUNCE_CYCLES consecutive samples -> IDLE.
- RELEASE_WAIT, any key sampled -> HELD.
REQ-022 SHALL produce exactly one accept per debounced press, regardless of hold length.
REQ-023 SHALL, on accept when Full=0, shift Digits left by 4, insert D in [3:0] and increment DigitCount.
REQ-024 SHALL, on accept when Full=1, still pulse loadn and update D, but leave Digits and DigitCount unchanged (saturate).
REQ-025 SHALL make Clear zero Digits and DigitCount.
REQ-026 SHALL give Clear priority when Clear and accept occur in the same cycle: the digit is discarded, while loadn and D behave per REQ-020.
REQ-027 SHALL hold the FSM in IDLE with count 0 while Enablen=1; keys are ignored.
REQ-028 SHALL, when Enablen rises mid-press, abort the press with no loadn pulse.
REQ-029 SHALL keep the divider counter at 0 while Enablen=0.
REQ-030 SHALL, while Enablen=1, count the divider 0..DIV_RATIO-1 and wrap to 0.
REQ-031 SHALL, while Enablen=1, pulse pgt_1Hz for one cycle on the wrap edge; the first tick comes DIV_RATIO cycles after Enablen rises.
REQ-032 SHALL, while Enablen=0, make pgt_1Hz equal the inverse of loadn, i.e. one pulse per accept.
REQ-033 SHALL register every output; there is no combinational path from inputs to outputs.

Reset
REQ-034 SHALL, while Reset=1, set: FSM IDLE, stable count 0, divider 0, D=0, loadn=1, pgt_1Hz=0, Digits=0, DigitCount=0, Full=0.
REQ-035 SHALL give Reset priority over Clear, Enablen and Keypad; a press in progress is discarded.
REQ-036 SHALL drive no loadn pulse in the cycle after Reset is released.

Verification
REQ-037 SHALL cover a clean press (defaults, Enablen=0): Keypad[7] held for 10 cycles -> loadn low for exactly 1 cycle, 4 edges after the first sample; D=7; Digits=0x0007; DigitCount=1; a single pgt_1Hz pulse.
REQ-038 SHALL cover bounce and priority: Keypad toggles bit3 on/off every cycle for 6 cycles, then Keypad[2] and Keypad[5] held together -> no accept during the bounce; one accept with D=5.
REQ-039 SHALL cover entry and saturation: keys 1,2,3,4,5 entered with releases -> Digits=0x1234, Full=1 after the 4th key; the 5th key pulses loadn with D=5 and Digits unchanged.
REQ-040 SHALL cover run mode: Enablen=1 for 250 cycles -> pgt_1Hz pulses at cycles 100 and 200 after the rise; Keypad activity produces no loadn.
REQ-041 SHALL cover Clear with a simultaneous accept: Digits=0x0012, Clear asserted on the accept edge of key 9 -> Digits=0, DigitCount=0, loadn pulses, D=9.
REQ-042 SHALL cover reset mid-press: Keypad[4] held, Reset pulsed in PRESS_WAIT -> all outputs at reset values; a fresh accept of key 4 arrives DEBOUNCE_CYCLES edges after Reset deasserts.

Source files
------------

// File: rtl/keypad_encoder_n_if.sv
// Keypad encoder bus: raw keys and mode controls in,
// debounced key code, strobes and digit register out.
interface keypad_encoder_n_if #(
  parameter int NUM_KEYS = 10,
  parameter int DIGITS   = 4
);
  localparam int NW = $clog2(DIGITS + 1);

  logic [NUM_KEYS-1:0] Keypad;
  logic                Enablen;
  logic                Clear;
  logic [3:0]          D;
  logic                loadn;
  logic                pgt_1Hz;
  logic [4*DIGITS-1:0] Digits;
  logic [NW-1:0]       DigitCount;
  logic                Full;

  modport master (
    output Keypad,
    output Enablen,
    output Clear,
    input  D,
    input  loadn,
    input  pgt_1Hz,
    input  Digits,
    input  DigitCount,
    input  Full
  );

  modport slave (
    input  Keypad,
    input  Enablen,
    input  Clear,
    output D,
    output loadn,
    output pgt_1Hz,
    output Digits,
    output DigitCount,
    output Full
  );
endinterface

// File: rtl/keypad_encoder_n.sv
// Debounced priority keypad encoder with BCD digit entry
// register and a run-mode clock-enable divider.
module keypad_encoder_n #(
  parameter int NUM_KEYS        = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIV_RATIO       = 100,
  parameter int DIGITS          = 4
) (
  input logic               Clk,
  input logic               Reset,
  keypad_encoder_n_if.slave bus
);
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW1 = CW + 1;
  localparam int DW  = $clog2(DIV_RATIO);
  localparam int NW  = $clog2(DIGITS + 1);
  localparam int BW  = 4 * DIGITS;

  localparam logic [CW1-1:0] DEB_N =
    CW1'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DIV_MAX =
    DW'(DIV_RATIO - 1);
  localparam logic [NW-1:0]  DIG_N =
    NW'(DIGITS);
  localparam logic           ONE_DEB =
    (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [3:0]     pcode;
  logic [DW-1:0]  div;
  logic [3:0]     d_q;
  logic           loadn_q;
  logic           pgt_q;
  logic [BW-1:0]  dig_q;
  logic [NW-1:0]  dcnt_q;
  logic           full_q;

  logic [3:0]     code;
  logic           hit;
  logic [CW1-1:0] cnt_inc;
  logic           done;
  logic           accept;
  logic [BW-1:0]  dig_sh;
  logic [NW-1:0]  dcnt_inc;
  logic           div_wrap;

  // Ascending scan: the last set bit seen is the highest index.
  always_comb begin
    code = 4'd0;
    hit  = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (bus.Keypad[i]) begin
        code = 4'(i);
        hit  = 1'b1;
      end
    end
  end

  assign cnt_inc  = {1'b0, cnt} + 1'b1;
  assign done     = (cnt_inc >= DEB_N);
  assign dcnt_inc = dcnt_q + 1'b1;
  assign div_wrap = (div == DIV_MAX);

  always_comb begin
    accept = 1'b0;
    if (!bus.Enablen && hit) begin
      unique case (state)
        IDLE:       accept = ONE_DEB;
        PRESS_WAIT: accept = (code == pcode) ?
                             done : ONE_DEB;
        default:    accept = 1'b0;
      endcase
    end
  end

  always_comb begin
    dig_sh      = dig_q << 4;
    dig_sh[3:0] = code;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pcode   <= 4'd0;
      div     <= '0;
      d_q     <= 4'd0;
      loadn_q <= 1'b1;
      pgt_q   <= 1'b0;
      dig_q   <= '0;
      dcnt_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      loadn_q <= ~accept;
      if (accept) begin
        d_q <= code;
      end

      if (bus.Clear) begin
        dig_q  <= '0;
        dcnt_q <= '0;
        full_q <= 1'b0;
      end else if (accept && !full_q) begin
        dig_q  <= dig_sh;
        dcnt_q <= dcnt_inc;
        full_q <= (dcnt_inc == DIG_N);
      end

      if (bus.Enablen) begin
        div   <= div_wrap ? '0 : div + 1'b1;
        pgt_q <= div_wrap;
      end else begin
        div   <= '0;
        pgt_q <= accept;
      end

      // Run mode parks the debouncer and drops any press.
      if (bus.Enablen) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (hit) begin
              pcode <= code;
              if (accept) begin
                state <= HELD;
                cnt   <= '0;
              end else begin
                state <= PRESS_WAIT;
                cnt   <= CW'(1);
              end
            end
          end
          PRESS_WAIT: begin
            if (!hit) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (accept) begin
              state <= HELD;
              pcode <= code;
              cnt   <= '0;
            end else if (code == pcode) begin
              cnt <= cnt_inc[CW-1:0];
            end else begin
              pcode <= code;
              cnt   <= CW'(1);
            end
          end
          HELD: begin
            if (!hit) begin
              if (ONE_DEB) begin
                state <= IDLE;
                cnt   <= '0;
              end else begin
                state <= RELEASE_WAIT;
                cnt   <= CW'(1);
              end
            end
          end
          RELEASE_WAIT: begin
            if (hit) begin
              state <= HELD;
              cnt   <= '0;
            end else if (done) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc[CW-1:0];
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.D          = d_q;
  assign bus.loadn      = loadn_q;
  assign bus.pgt_1Hz    = pgt_q;
  assign bus.Digits     = dig_q;
  assign bus.DigitCount = dcnt_q;
  assign bus.Full       = full_q;
endmodule

// File: tb/tb_keypad_encoder_n.sv
// Scoreboard bench for keypad_encoder_n: run-length
// reference model feeds accept/tick queues, monitor pops.
module tb_keypad_encoder_n;
  localparam int NK  = 10;
  localparam int DEB = 4;
  localparam int DIV = 100;
  localparam int ND  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_encoder_n_if #(.NUM_KEYS(NK), .DIGITS(ND)) bus ();

  keypad_encoder_n #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DEB),
    .DIV_RATIO(DIV),
    .DIGITS(ND)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int d;
    int dig;
    int cnt;
    bit full;
  } acc_t;

  acc_t acc_q[$];
  int   tick_q[$];
  acc_t e;
  int   te;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ticks_seen = 0;

  bit   armed = 1'b1;
  int   run_code = -1;
  int   run_len = 0;
  int   none_len = 0;
  int   en_run = 0;
  int   dq[$];
  int   last_d = 0;

  function automatic int dig_val();
    int v;
    v = 0;
    foreach (dq[i]) v = (v << 4) | dq[i];
    return v;
  endfunction

  // Accept when an armed keypad shows the same key for DEB
  // samples in a row; re-arm after DEB idle samples.
  task automatic model(input logic [NK-1:0] k,
                       input bit en, input bit clr,
                       input bit r);
    int c;
    bit acc;
    c = -1;
    acc = 1'b0;
    for (int i = 0; i < NK; i++) if (k[i]) c = i;
    if (r) begin
      armed = 1'b1;
      run_len = 0;
      none_len = 0;
      en_run = 0;
      dq.delete();
      last_d = 0;
      return;
    end
    if (en) begin
      armed = 1'b1;
      run_len = 0;
      none_len = 0;
      en_run++;
      if (en_run % DIV == 0) tick_q.push_back(cyc + 1);
    end else begin
      en_run = 0;
      if (c < 0) begin
        run_len = 0;
        none_len++;
        if (none_len >= DEB) armed = 1'b1;
      end else begin
        none_len = 0;
        if (run_len > 0 && c == run_code) run_len++;
        else begin
          run_code = c;
          run_len = 1;
        end
        if (armed && run_len >= DEB) begin
          acc = 1'b1;
          armed = 1'b0;
        end
      end
    end
    if (clr) dq.delete();
    else if (acc && dq.size() < ND) dq.push_back(c);
    if (acc) begin
      last_d = c;
      acc_q.push_back('{cyc + 1, c, dig_val(),
                        dq.size(), dq.size() == ND});
    end
  endtask

  task automatic step(input logic [NK-1:0] k,
                      input bit en, input bit clr,
                      input bit r);
    bus.Keypad  = k;
    bus.Enablen = en;
    bus.Clear   = clr;
    rst         = r;
    model(k, en, clr, r);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string n, input int a,
                     input int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, x);
    end
  endtask

  task automatic chk_reset();
    chk("rst_D", int'(bus.D), 0);
    chk("rst_loadn", int'(bus.loadn), 1);
    chk("rst_pgt", int'(bus.pgt_1Hz), 0);
    chk("rst_Digits", int'(bus.Digits), 0);
    chk("rst_DigitCount", int'(bus.DigitCount), 0);
    chk("rst_Full", int'(bus.Full), 0);
  endtask

  task automatic chk_state(input string n);
    chk({n, "_D"}, int'(bus.D), last_d);
    chk({n, "_Digits"}, int'(bus.Digits), dig_val());
    chk({n, "_Count"}, int'(bus.DigitCount), dq.size());
    chk({n, "_Full"}, int'(bus.Full),
        int'(dq.size() == ND));
  endtask

  always @(negedge clk) begin
    if (bus.loadn === 1'b0) begin
      checks++;
      if (acc_q.size() == 0) begin
        errors++;
        $display("FAIL accept: loadn low at cycle %0d, none expected",
                 cyc);
      end else begin
        e = acc_q.pop_front();
        if (cyc != e.cyc || bus.D != 4'(e.d) ||
            bus.Digits != 16'(e.dig) ||
            bus.DigitCount != 3'(e.cnt) ||
            bus.Full != e.full || bus.pgt_1Hz !== 1'b1) begin
          errors++;
          $display("FAIL accept: got cyc=%0d D=%0h Dig=%h n=%0d F=%b p=%b want cyc=%0d D=%0h Dig=%h n=%0d F=%b p=1",
                   cyc, bus.D, bus.Digits, bus.DigitCount,
                   bus.Full, bus.pgt_1Hz, e.cyc, e.d, e.dig,
                   e.cnt, e.full);
        end
      end
    end
    if (bus.pgt_1Hz === 1'b1 && bus.loadn === 1'b1) begin
      checks++;
      ticks_seen++;
      if (tick_q.size() == 0) begin
        errors++;
        $display("FAIL tick: pgt_1Hz at cycle %0d, none expected",
                 cyc);
      end else begin
        te = tick_q.pop_front();
        if (te != cyc) begin
          errors++;
          $display("FAIL tick: got cycle %0d want %0d", cyc, te);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int len;
    int mode;
    bit en;
    logic [NK-1:0] k;
    bus.Keypad  = '0;
    bus.Enablen = 1'b0;
    bus.Clear   = 1'b0;

    repeat (3) step('0, 0, 0, 1);
    chk_reset();
    repeat (2) step('0, 0, 0, 0);
    chk("post_rst_loadn", int'(bus.loadn), 1);

    repeat (10) step(10'h080, 0, 0, 0);
    repeat (6) step('0, 0, 0, 0);
    chk("clean_D", int'(bus.D), 7);
    chk("clean_Digits", int'(bus.Digits), 'h0007);
    chk("clean_Count", int'(bus.DigitCount), 1);

    for (int i = 0; i < 6; i++)
      step((i % 2 == 0) ? 10'h008 : 10'h000, 0, 0, 0);
    chk("bounce_noacc", int'(bus.Digits), 'h0007);
    repeat (8) step(10'h024, 0, 0, 0);
    repeat (6) step('0, 0, 0, 0);
    chk("prio_D", int'(bus.D), 5);
    chk("prio_Digits", int'(bus.Digits), 'h0075);

    step('0, 0, 1, 0);
    for (int kk = 1; kk <= 5; kk++) begin
      repeat (6) step(NK'(1 << kk), 0, 0, 0);
      repeat (6) step('0, 0, 0, 0);
      if (kk == 4) begin
        chk("entry_Digits", int'(bus.Digits), 'h1234);
        chk("entry_Full", int'(bus.Full), 1);
      end
    end
    chk("sat_D", int'(bus.D), 5);
    chk("sat_Digits", int'(bus.Digits), 'h1234);
    chk("sat_Count", int'(bus.DigitCount), 4);
    chk_state("sat");

    step('0, 0, 1, 0);
    for (int kk = 1; kk <= 2; kk++) begin
      repeat (6) step(NK'(1 << kk), 0, 0, 0);
      repeat (6) step('0, 0, 0, 0);
    end
    chk("clr_pre", int'(bus.Digits), 'h0012);
    repeat (3) step(NK'(1 << 9), 0, 0, 0);
    step(NK'(1 << 9), 0, 1, 0);
    repeat (4) step(NK'(1 << 9), 0, 0, 0);
    repeat (6) step('0, 0, 0, 0);
    chk("clracc_D", int'(bus.D), 9);
    chk("clracc_Digits", int'(bus.Digits), 0);
    chk("clracc_Count", int'(bus.DigitCount), 0);

    t0 = ticks_seen;
    repeat (250) step(NK'($urandom_range(0, 1023)), 1, 0, 0);
    repeat (4) step('0, 0, 0, 0);
    chk("run_ticks", ticks_seen - t0, 2);
    chk_state("run");

    repeat (2) step(NK'(1 << 4), 0, 0, 0);
    step(NK'(1 << 4), 0, 0, 1);
    chk_reset();
    repeat (6) step(NK'(1 << 4), 0, 0, 0);
    repeat (6) step('0, 0, 0, 0);
    chk("rstpress_D", int'(bus.D), 4);
    chk("rstpress_Digits", int'(bus.Digits), 'h0004);

    repeat (2) step(NK'(1 << 6), 0, 0, 0);
    repeat (3) step(NK'(1 << 6), 1, 0, 0);
    repeat (6) step('0, 0, 0, 0);
    chk("abort_D", int'(bus.D), 4);

    for (int n = 0; n < 150; n++) begin
      len  = $urandom_range(1, 8);
      mode = $urandom_range(0, 9);
      en   = ($urandom_range(0, 15) == 0);
      if (mode < 4) k = '0;
      else if (mode < 8) k = NK'(1 << $urandom_range(0, NK - 1));
      else k = NK'($urandom_range(0, 1023));
      for (int j = 0; j < len; j++)
        step(k, en, $urandom_range(0, 29) == 0,
             $urandom_range(0, 149) == 0);
    end
    repeat (6) step('0, 0, 0, 0);
    chk_state("rand");

    chk("acc_q_empty", acc_q.size(), 0);
    chk("tick_q_empty", tick_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
